// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper move controller: FSM states, direction
// encoding and the 8-phase coil table.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Entry [i] is the coil pattern for phase i; odd phases energise two coils.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic logic [2:0] phase_advance(input logic [2:0] phase,
                                               input logic       dir,
                                               input logic [1:0] amt);
    return (dir == DIR_FWD) ? phase + 3'(amt) : phase - 3'(amt);
  endfunction

endpackage

// File: rtl/step_rate_div.sv
// Step-period divider: counts 0..rate while enabled and emits a one-cycle
// tick on the terminal count, restarting from zero.
module step_rate_div
  import stepper_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_16,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] rate,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !clear && (cnt == rate);

  always_ff @(posedge clk_16 or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Absolute-position move controller for one 4-wire unipolar stepper:
// steps toward a latched signed target in half- or full-step mode.
//
//  state   | meaning
//  IDLE    | waiting for start; coils held or released per hold_en; zero allowed
//  MOVE    | stepping toward latched target, one step per divider tick
//  DONE    | arrived; done pulses for this single cycle
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int POS_W = 12,
  parameter int DIV_W = 8
) (
  input  logic             clk_16,
  input  logic             rst,
  input  logic             start,
  input  logic [POS_W-1:0] target,
  input  logic             half_step,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             abort,
  input  logic             hold_en,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] pos,
  output logic [3:0]       stepper_pins
);

  state_t           state;
  logic [2:0]       phase;
  logic [POS_W-1:0] target_l;
  logic             half_l;
  logic [DIV_W-1:0] rate_l;

  logic             div_clear;
  logic             tick;
  logic [POS_W:0]   diff;
  logic             dir;
  logic [1:0]       step_amt;
  logic [2:0]       phase_next;
  logic [POS_W-1:0] pos_next;

  assign div_clear = (state != ST_MOVE);

  step_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .clk_16 (clk_16),
    .rst    (rst),
    .clear  (div_clear),
    .rate   (rate_l),
    .tick   (tick)
  );

  // Distance is taken one bit wider so the sign is never lost to wrap.
  always_comb begin
    diff     = {target_l[POS_W-1], target_l} - {pos[POS_W-1], pos};
    dir      = diff[POS_W] ? DIR_REV : DIR_FWD;
    step_amt = 2'd2;
    if (half_l || !phase[0] ||
        diff == {{POS_W{1'b0}}, 1'b1} || diff == {(POS_W+1){1'b1}}) begin
      step_amt = 2'd1;
    end
    phase_next = phase_advance(phase, dir, step_amt);
    pos_next   = (dir == DIR_FWD) ? pos + POS_W'(step_amt)
                                  : pos - POS_W'(step_amt);
  end

  always_ff @(posedge clk_16 or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      phase        <= 3'd0;
      pos          <= '0;
      target_l     <= '0;
      half_l       <= 1'b0;
      rate_l       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stepper_pins <= 4'b0000;
    end else begin
      // Pins follow the phase register, so they trail each step by one cycle.
      stepper_pins <= (state != ST_IDLE || hold_en) ? PHASE_TABLE[phase] : 4'b0000;
      done         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            target_l <= target;
            half_l   <= half_step;
            rate_l   <= rate_div;
            if (target == pos) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_MOVE;
              busy  <= 1'b1;
            end
          end else if (zero) begin
            pos <= '0;
          end
        end
        ST_MOVE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            pos   <= pos_next;
            phase <= phase_next;
            if (pos_next == target_l) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Self-checking bench for stepper_move_ctrl: vector table, hand-written corner
// sequences and randomized moves against an arithmetic reference model.
module tb_stepper_move_ctrl;

  localparam int POS_W = 12;
  localparam int DIV_W = 8;

  logic             clk_16;
  logic             rst;
  logic             start;
  logic [POS_W-1:0] target;
  logic             half_step;
  logic [DIV_W-1:0] rate_div;
  logic             abort;
  logic             hold_en;
  logic             zero;
  logic             busy;
  logic             done;
  logic [POS_W-1:0] pos;
  logic [3:0]       stepper_pins;

  int n_checks = 0;
  int n_fail   = 0;

  stepper_move_ctrl #(.POS_W(POS_W), .DIV_W(DIV_W)) dut (
    .clk_16       (clk_16),
    .rst          (rst),
    .start        (start),
    .target       (target),
    .half_step    (half_step),
    .rate_div     (rate_div),
    .abort        (abort),
    .hold_en      (hold_en),
    .zero         (zero),
    .busy         (busy),
    .done         (done),
    .pos          (pos),
    .stepper_pins (stepper_pins)
  );

  initial clk_16 = 1'b0;
  always #5 clk_16 = ~clk_16;

  function automatic logic [3:0] coil(input int idx);
    case (idx & 7)
      0: return 4'b1000;
      1: return 4'b1100;
      2: return 4'b0100;
      3: return 4'b0110;
      4: return 4'b0010;
      5: return 4'b0011;
      6: return 4'b0001;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic int spos();
    return int'($signed(pos));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_16);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; zero = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic launch(input bit h, input int rate, input int tgt);
    half_step = h; rate_div = DIV_W'(rate); target = POS_W'(tgt); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  typedef struct {
    bit         half;
    int         rate;
    int         tgt;
    int         exp_cycles;
    int         exp_pos;
    logic [3:0] exp_pins;
  } vec_t;

  vec_t vecs[8];

  // Random-test reference model: position and phase as plain integers.
  int mpos, mphase;

  initial begin
    int n, k, tgt, rate, prev, amt, dir, diff, abort_at;
    bit h, fin, do_abort, exp_done, exp_busy, ab;
    logic [3:0] pin_seq[6];
    logic [3:0] pin_rev[4];

    vecs[0] = '{1'b1, 0,  5,  5,  5, 4'b0011};
    vecs[1] = '{1'b0, 3,  7, 16,  7, 4'b1001};
    vecs[2] = '{1'b1, 0, -3,  3, -3, 4'b0011};
    vecs[3] = '{1'b0, 1,  2,  4,  2, 4'b0100};
    vecs[4] = '{1'b0, 0, -4,  3, -4, 4'b0010};
    vecs[5] = '{1'b1, 2,  1,  3,  1, 4'b1100};
    vecs[6] = '{1'b0, 5,  0,  0,  0, 4'b1000};
    vecs[7] = '{1'b0, 0,  6,  4,  6, 4'b0001};
    pin_seq = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011};
    pin_rev = '{4'b1000, 4'b1001, 4'b0001, 4'b0011};

    hold_en = 1'b0; half_step = 1'b0; rate_div = '0; target = '0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; zero = 1'b0;
    #2;
    check("reset_pos",  spos(), 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pins", stepper_pins, 0);
    cyc(); rst = 1'b0;

    // Vector table: each move from a fresh reset (pos 0, phase 0).
    hold_en = 1'b1;
    foreach (vecs[i]) begin
      do_reset();
      launch(vecs[i].half, vecs[i].rate, vecs[i].tgt);
      n = 0;
      while (!done && n < 200) begin cyc(); n++; end
      check($sformatf("vec%0d_cycles", i), n, vecs[i].exp_cycles);
      check($sformatf("vec%0d_pos", i), spos(), vecs[i].exp_pos);
      check($sformatf("vec%0d_busy_at_done", i), busy, 0);
      cyc();
      check($sformatf("vec%0d_done_width", i), done, 0);
      check($sformatf("vec%0d_pins", i), stepper_pins, vecs[i].exp_pins);
    end

    // Half-step forward: pin sequence and single done pulse.
    do_reset();
    launch(1'b1, 0, 5);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check($sformatf("fwd_pins_c%0d", i), stepper_pins, pin_seq[i-1]);
      check($sformatf("fwd_done_c%0d", i), done, (i == 5) ? 1 : 0);
    end

    // Half-step reverse from zero.
    do_reset();
    launch(1'b1, 0, -3);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("rev_pins_c%0d", i), stepper_pins, pin_rev[i-1]);
      if (i <= 3) check($sformatf("rev_pos_c%0d", i), spos(), -i);
    end

    // start with target == pos: done next cycle, busy never, pins unchanged.
    do_reset();
    cyc();
    launch(1'b0, 2, 0);
    check("same_done", done, 1);
    check("same_busy", busy, 0);
    check("same_pins", stepper_pins, 4'b1000);
    cyc();
    check("same_done_low", done, 0);
    check("same_busy_low", busy, 0);
    check("same_pins_after", stepper_pins, 4'b1000);

    // Abort during a 10-step move; a start mid-move must be ignored.
    do_reset();
    launch(1'b1, 0, 10);
    check("abort_busy_hi", busy, 1);
    start = 1'b1; target = POS_W'(-5);
    cyc();
    start = 1'b0; abort = 1'b1;
    check("abort_pos_c1", spos(), 1);
    cyc();
    abort = 1'b0;
    check("abort_busy_lo", busy, 0);
    check("abort_pos_hold", spos(), 1);
    check("abort_done", done, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin cyc(); n += done; end
    check("abort_no_done", n, 0);
    check("abort_pos_later", spos(), 1);

    // Zero in IDLE, coil release, and reset in the middle of a move.
    do_reset();
    launch(1'b1, 0, 3);
    n = 0;
    while (!done && n < 50) begin cyc(); n++; end
    cyc();
    zero = 1'b1; cyc(); zero = 1'b0;
    check("zero_pos", spos(), 0);
    hold_en = 1'b0; cyc();
    check("release_pins", stepper_pins, 0);
    hold_en = 1'b1; cyc();
    check("zero_keeps_phase", stepper_pins, 4'b0110);
    launch(1'b1, 0, 20);
    cyc(); cyc();
    check("pre_rst_pos", spos(), 2);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_pos", spos(), 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_pins", stepper_pins, 0);
    cyc();
    rst = 1'b0;

    // Randomized moves against the model, with junk starts and random aborts.
    do_reset();
    mpos = 0; mphase = 0;
    for (int m = 0; m < 40; m++) begin
      h = 1'($urandom_range(0, 1));
      rate = $urandom_range(0, 3);
      tgt = mpos + $urandom_range(0, 30) - 15;
      do_abort = ($urandom_range(0, 4) == 0);
      abort_at = $urandom_range(1, 6);
      launch(h, rate, tgt);
      if (tgt == mpos) begin
        check("rnd_same_done", done, 1);
        check("rnd_same_busy", busy, 0);
        cyc();
        continue;
      end
      check("rnd_accept_busy", busy, 1);
      k = 0; fin = 0;
      while (!fin && k < 500) begin
        k++;
        ab = do_abort && (k == abort_at);
        abort = ab;
        start = ($urandom_range(0, 3) == 0);
        target = POS_W'(mpos + $urandom_range(0, 40) - 20);
        cyc();
        prev = mphase;
        exp_done = 0; exp_busy = 1;
        if (ab) begin
          fin = 1; exp_busy = 0;
        end else if (k % (rate + 1) == 0) begin
          diff = tgt - mpos;
          dir = (diff > 0) ? 1 : -1;
          if (h || (mphase % 2 == 0) || diff == 1 || diff == -1) amt = 1;
          else amt = 2;
          mpos += dir * amt;
          mphase = (mphase + dir * amt + 8) % 8;
          if (mpos == tgt) begin fin = 1; exp_done = 1; exp_busy = 0; end
        end
        check("rnd_pos", spos(), mpos);
        check("rnd_busy", busy, exp_busy);
        check("rnd_done", done, exp_done);
        check("rnd_pins", stepper_pins, coil(prev));
      end
      if (!fin) check("rnd_timeout", k, -1);
      abort = 1'b0; start = 1'b0;
      cyc();
      check("rnd_idle_done", done, 0);
      check("rnd_idle_pins", stepper_pins, coil(mphase));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
